// File: rtl/crypto_pkg.sv
// Shared state encoding, key-mode codes and default sizes for the XOR-encryption sequencer.
package crypto_pkg;
    localparam int MSG_SIZE_DEF = 64;
    localparam int KEY_SIZE_DEF = 8;
    localparam int TIMEOUT_DEF  = 255;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_MSG,
        ENCRYPT,
        DRAIN,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] KEY_MODE_LOADED = 2'b00;
    localparam logic [1:0] KEY_MODE_FIXED  = 2'b01;
    localparam logic [1:0] KEY_MODE_ZERO   = 2'b10;
    localparam logic [1:0] KEY_MODE_RSVD   = 2'b11;
endpackage

// File: rtl/seq_watchdog.sv
// Loadable, clearable timeout counter; expire is combinational and high in the cycle whose
// closing edge would bring the count to TIMEOUT. Holds while ena is low; clr overrides ena.
module seq_watchdog import crypto_pkg::*; #(
    parameter int   TIMEOUT = TIMEOUT_DEF,
    localparam int  WW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          clr,
    input  logic          load,
    input  logic [WW-1:0] load_val,
    input  logic          run,
    output logic          expire
);
    localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT);
    localparam logic [WW-1:0] LAST  = WW'(TIMEOUT - 1);

    logic [WW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (ena) begin
            if (load) begin
                count <= load_val;
            end else if (run && count != LIMIT) begin
                count <= count + WW'(1);
            end
        end
    end

    assign expire = ena && run && !load && (count == LAST);
endmodule

// File: rtl/crypto_sequencer.sv
// Start-to-done control FSM for key load, message load, encrypt and ciphertext drain.
// First oKey_flag one clk after iStart; stages are verified against datapath bit counters.
module crypto_sequencer import crypto_pkg::*; #(
    parameter int  MSG_SIZE = MSG_SIZE_DEF,
    parameter int  KEY_SIZE = KEY_SIZE_DEF,
    parameter int  TIMEOUT  = TIMEOUT_DEF,
    localparam int KW       = $clog2(KEY_SIZE) + 1,
    localparam int CW       = $clog2(MSG_SIZE) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          iStart,
    input  logic          iAbort,
    input  logic [1:0]    iKey_mode,
    input  logic [KW-1:0] iKey_count,
    input  logic [CW-1:0] iMsg_count,
    input  logic          iEnc_done,
    input  logic          iCt_flag,
    output logic          oKey_flag,
    output logic          oMsg_flag,
    output logic          oEnc_start,
    output logic [1:0]    oKey_sel,
    output logic          oBusy,
    output logic          oDone,
    output logic          oError
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_SIZE - 1);
    localparam logic [CW-1:0] KEY_CHK  = CW'(KEY_SIZE);
    localparam logic [CW-1:0] MSG_LAST = CW'(MSG_SIZE - 1);
    localparam logic [CW-1:0] MSG_CHK  = CW'(MSG_SIZE);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ct_prev;
    logic          wd_run;
    logic          wd_load;
    logic          wd_expire;

    // The watchdog only runs in the two open-ended stages and restarts on each entry.
    assign wd_run  = (state == ENCRYPT) || (state == DRAIN);
    assign wd_load = !wd_run || ((state == ENCRYPT) && iEnc_done);

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .clr      (iAbort),
        .load     (wd_load),
        .load_val ({WW{1'b0}}),
        .run      (wd_run),
        .expire   (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ct_prev    <= 1'b0;
            oKey_flag  <= 1'b0;
            oMsg_flag  <= 1'b0;
            oEnc_start <= 1'b0;
            oKey_sel   <= 2'b00;
        end else if (iAbort) begin
            state      <= IDLE;
            cnt        <= '0;
            ct_prev    <= 1'b0;
            oKey_flag  <= 1'b0;
            oMsg_flag  <= 1'b0;
            oEnc_start <= 1'b0;
        end else if (ena) begin
            oEnc_start <= 1'b0;
            case (state)
                IDLE, ERROR: begin
                    if (iStart) begin
                        oKey_sel <= iKey_mode;
                        cnt      <= '0;
                        if (iKey_mode == KEY_MODE_RSVD) begin
                            state <= ERROR;
                        end else begin
                            state     <= LOAD_KEY;
                            oKey_flag <= 1'b1;
                        end
                    end
                end
                // cnt == KEY_CHK is the flag-low cycle in which the deserializer count is final.
                LOAD_KEY: begin
                    if (cnt == KEY_LAST) begin
                        oKey_flag <= 1'b0;
                        cnt       <= KEY_CHK;
                    end else if (cnt == KEY_CHK) begin
                        cnt <= '0;
                        if (iKey_count == KW'(KEY_SIZE)) begin
                            state     <= LOAD_MSG;
                            oMsg_flag <= 1'b1;
                        end else begin
                            state <= ERROR;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LOAD_MSG: begin
                    if (cnt == MSG_LAST) begin
                        oMsg_flag <= 1'b0;
                        cnt       <= MSG_CHK;
                    end else if (cnt == MSG_CHK) begin
                        cnt <= '0;
                        if (iMsg_count == MSG_CHK) begin
                            state      <= ENCRYPT;
                            oEnc_start <= 1'b1;
                        end else begin
                            state <= ERROR;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ENCRYPT: begin
                    if (iEnc_done) begin
                        state   <= DRAIN;
                        cnt     <= '0;
                        ct_prev <= 1'b0;
                    end else if (wd_expire) begin
                        state <= ERROR;
                    end
                end
                DRAIN: begin
                    if (ct_prev && !iCt_flag) begin
                        state <= (cnt == MSG_CHK) ? DONE : ERROR;
                    end else if (wd_expire) begin
                        state <= ERROR;
                    end else begin
                        ct_prev <= iCt_flag;
                        if (iCt_flag && cnt != CNT_MAX) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign oBusy  = wd_run || (state == LOAD_KEY) || (state == LOAD_MSG);
    assign oDone  = (state == DONE);
    assign oError = (state == ERROR);
endmodule
